// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the writeback-stage trap/MRET sequencer:
//   - synchronous exception cause codes
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - FSM state encoding
//   - mtval source selector codes and the priority-encoder result struct
//   - helpers that build the mstatus value written on trap entry and on MRET
// -----------------------------------------------------------------------------
package trap_pkg;

  localparam int XLEN_SUPPORTED = 32;

  // Exception cause codes (mcause[3:0]; mcause[31] is always 0 here)
  localparam logic [3:0] CAUSE_FETCH_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_TRAP     = 2'd1;
  localparam logic [1:0] ST_MRET     = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  // Source of the mtval value for the winning exception
  localparam logic [1:0] MTVAL_ZERO    = 2'd0;
  localparam logic [1:0] MTVAL_BADADDR = 2'd1;
  localparam logic [1:0] MTVAL_INSTR   = 2'd2;

  typedef struct packed {
    logic       exc;
    logic [3:0] cause;
    logic [1:0] mtval_sel;
  } prio_t;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= mpp
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms,
                                               input logic [1:0]  mpp);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp;
    return r;
  endfunction

  // MRET: MIE <= MPIE, MPIE <= 1, MPP <= mpp (M-mode only core)
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms,
                                               input logic [1:0]  mpp);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp;
    return r;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// -----------------------------------------------------------------------------
// trap_prio_enc
// Combinational priority encoder for the six synchronous exception flags of
// the retiring instruction.
// Ports:
//   fetch_misalign_i .. store_misalign_i : raw exception flags
//   prio_o : {exc, cause[3:0], mtval_sel[1:0]} of the highest-priority flag
// Priority (highest first): fetch misalign, illegal, ecall, ebreak,
// load misalign, store misalign.
// -----------------------------------------------------------------------------
module trap_prio_enc
  import trap_pkg::*;
(
  input  logic  fetch_misalign_i,
  input  logic  illegal_i,
  input  logic  ecall_i,
  input  logic  ebreak_i,
  input  logic  load_misalign_i,
  input  logic  store_misalign_i,
  output prio_t prio_o
);

  always_comb begin
    prio_o = '{exc: 1'b0, cause: 4'd0, mtval_sel: MTVAL_ZERO};
    if (fetch_misalign_i) begin
      prio_o = '{exc: 1'b1, cause: CAUSE_FETCH_MISALIGN, mtval_sel: MTVAL_BADADDR};
    end else if (illegal_i) begin
      prio_o = '{exc: 1'b1, cause: CAUSE_ILLEGAL, mtval_sel: MTVAL_INSTR};
    end else if (ecall_i) begin
      prio_o = '{exc: 1'b1, cause: CAUSE_ECALL_M, mtval_sel: MTVAL_ZERO};
    end else if (ebreak_i) begin
      prio_o = '{exc: 1'b1, cause: CAUSE_BREAKPOINT, mtval_sel: MTVAL_ZERO};
    end else if (load_misalign_i) begin
      prio_o = '{exc: 1'b1, cause: CAUSE_LOAD_MISALIGN, mtval_sel: MTVAL_BADADDR};
    end else if (store_misalign_i) begin
      prio_o = '{exc: 1'b1, cause: CAUSE_STORE_MISALIGN, mtval_sel: MTVAL_BADADDR};
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Writeback-stage synchronous-exception and MRET sequencer.
// Accepts one event per retiring instruction (valid_i), prioritises the
// exception flags, writes mcause/mepc/mtval/mstatus through the CSR exception
// port for one cycle (we_exc_o), then redirects fetch for one cycle
// (redirect_o) to mtvec BASE on a trap or to mepc on MRET.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   valid_i, pc_i, instr_i, badaddr_i : retiring instruction info
//   *_misalign_i, illegal_i, ecall_i, ebreak_i, mret_i : event flags
//   mstatus_i, mepc_i, mcause_i, mtvec_i : current CSR values
//   we_exc_o, mcause_o, mepc_o, mtval_o, mstatus_o : CSR exception write port
//   flush_o, busy_o       : pipeline kill / stall while sequencing
//   redirect_o, redirect_pc_o : fetch redirect strobe and target
// -----------------------------------------------------------------------------
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter logic [1:0] MPP_MODE = 2'b11
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] badaddr_i,
  input  logic            fetch_misalign_i,
  input  logic            illegal_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            load_misalign_i,
  input  logic            store_misalign_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic [XLEN-1:0] mtvec_i,
  output logic            we_exc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mtval_o,
  output logic [XLEN-1:0] mstatus_o,
  output logic            flush_o,
  output logic            busy_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  prio_t prio;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] mtval_sel_val;

  // Low address bits are dropped: mepc is word-aligned and mtvec MODE is
  // ignored for synchronous exceptions.
  logic unused_low_bits;
  assign unused_low_bits = ^{pc_i[1:0], mtvec_i[1:0]};

  trap_prio_enc u_prio (
    .fetch_misalign_i (fetch_misalign_i),
    .illegal_i        (illegal_i),
    .ecall_i          (ecall_i),
    .ebreak_i         (ebreak_i),
    .load_misalign_i  (load_misalign_i),
    .store_misalign_i (store_misalign_i),
    .prio_o           (prio)
  );

  always_comb begin
    case (prio.mtval_sel)
      MTVAL_BADADDR: mtval_sel_val = badaddr_i;
      MTVAL_INSTR:   mtval_sel_val = instr_i;
      default:       mtval_sel_val = '0;
    endcase
  end

  // The CSR write values are computed when the event is accepted and held in
  // the output registers; the pipeline is stalled from then on, so mstatus_i
  // cannot change between acceptance and the write strobe.
  always_comb begin
    state_d       = state_q;
    mcause_d      = mcause_q;
    mepc_d        = mepc_q;
    mtval_d       = mtval_q;
    mstatus_d     = mstatus_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (prio.exc) begin
            state_d   = ST_TRAP;
            mcause_d  = {{(XLEN-4){1'b0}}, prio.cause};
            mepc_d    = {pc_i[XLEN-1:2], 2'b00};
            mtval_d   = mtval_sel_val;
            mstatus_d = trap_mstatus(mstatus_i, MPP_MODE);
          end else if (mret_i) begin
            state_d   = ST_MRET;
            mcause_d  = mcause_i;
            mepc_d    = mepc_i;
            mtval_d   = '0;
            mstatus_d = mret_mstatus(mstatus_i, MPP_MODE);
          end
        end
      end
      ST_TRAP: begin
        state_d       = ST_REDIRECT;
        redirect_pc_d = {mtvec_i[XLEN-1:2], 2'b00};
      end
      ST_MRET: begin
        state_d       = ST_REDIRECT;
        redirect_pc_d = mepc_i;
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      mcause_q      <= '0;
      mepc_q        <= '0;
      mtval_q       <= '0;
      mstatus_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      mcause_q      <= mcause_d;
      mepc_q        <= mepc_d;
      mtval_q       <= mtval_d;
      mstatus_q     <= mstatus_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Strobes decode directly from the state so reset clears them immediately.
  assign we_exc_o      = (state_q == ST_TRAP) || (state_q == ST_MRET);
  assign redirect_o    = (state_q == ST_REDIRECT);
  assign flush_o       = (state_q != ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign mcause_o      = mcause_q;
  assign mepc_o        = mepc_q;
  assign mtval_o       = mtval_q;
  assign mstatus_o     = mstatus_q;
  assign redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
// Directed, table-driven bench for trap_ctrl plus hand-written sequences for
// back-to-back events while busy and reset in the middle of a trap.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] pc_i, instr_i, badaddr_i;
  logic        fetch_misalign_i, illegal_i, ecall_i, ebreak_i;
  logic        load_misalign_i, store_misalign_i, mret_i;
  logic [31:0] mstatus_i, mepc_i, mcause_i, mtvec_i;
  logic        we_exc_o, flush_o, busy_o, redirect_o;
  logic [31:0] mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o;

  int checks = 0;
  int errors = 0;

  trap_ctrl #(.XLEN(32), .MPP_MODE(2'b11)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .valid_i          (valid_i),
    .pc_i             (pc_i),
    .instr_i          (instr_i),
    .badaddr_i        (badaddr_i),
    .fetch_misalign_i (fetch_misalign_i),
    .illegal_i        (illegal_i),
    .ecall_i          (ecall_i),
    .ebreak_i         (ebreak_i),
    .load_misalign_i  (load_misalign_i),
    .store_misalign_i (store_misalign_i),
    .mret_i           (mret_i),
    .mstatus_i        (mstatus_i),
    .mepc_i           (mepc_i),
    .mcause_i         (mcause_i),
    .mtvec_i          (mtvec_i),
    .we_exc_o         (we_exc_o),
    .mcause_o         (mcause_o),
    .mepc_o           (mepc_o),
    .mtval_o          (mtval_o),
    .mstatus_o        (mstatus_o),
    .flush_o          (flush_o),
    .busy_o           (busy_o),
    .redirect_o       (redirect_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  // flags = {fetch_misalign, illegal, ecall, ebreak, load_misalign, store_misalign}
  typedef struct {
    logic [5:0]  flags;
    logic        mret;
    logic [31:0] pc, instr, badaddr, mstatus, mepc, mcause, mtvec;
    logic [31:0] exp_mcause, exp_mepc, exp_mtval, exp_mstatus, exp_redirect;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    valid_i          = 1'b1;
    {fetch_misalign_i, illegal_i, ecall_i, ebreak_i,
     load_misalign_i, store_misalign_i} = v.flags;
    mret_i           = v.mret;
    pc_i             = v.pc;
    instr_i          = v.instr;
    badaddr_i        = v.badaddr;
    mstatus_i        = v.mstatus;
    mepc_i           = v.mepc;
    mcause_i         = v.mcause;
    mtvec_i          = v.mtvec;
  endtask

  task automatic clearEvents();
    valid_i = 1'b0;
    {fetch_misalign_i, illegal_i, ecall_i, ebreak_i,
     load_misalign_i, store_misalign_i} = 6'b0;
    mret_i = 1'b0;
  endtask

  task automatic stepClock();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    //            flags      mret  pc            instr         badaddr       mstatus       mepc          mcause        mtvec         exp_mcause exp_mepc    exp_mtval     exp_mstatus   exp_redirect
    vecs[0] = '{6'b010000, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0,        32'h0000_0008, 32'h0,        32'h0,        32'h0000_0200, 32'd2,  32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_1880, 32'h0000_0200};
    vecs[1] = '{6'b010010, 1'b1, 32'h0000_0104, 32'h1234_5678, 32'h0000_0055, 32'h0000_0000, 32'h0000_0999, 32'h0,       32'h0000_0300, 32'd2,  32'h0000_0104, 32'h1234_5678, 32'h0000_1800, 32'h0000_0300};
    vecs[2] = '{6'b000000, 1'b1, 32'h0000_0500, 32'h0,        32'h0,        32'h0000_1880, 32'h0000_0104, 32'h0000_0002, 32'h0000_0200, 32'd2,  32'h0000_0104, 32'h0,        32'h0000_1888, 32'h0000_0104};
    vecs[3] = '{6'b000010, 1'b0, 32'h0000_0040, 32'h0,        32'h0000_1003, 32'h0000_0000, 32'h0,        32'h0,        32'h0000_0201, 32'd4,  32'h0000_0040, 32'h0000_1003, 32'h0000_1800, 32'h0000_0200};
    vecs[4] = '{6'b111111, 1'b1, 32'h0000_0203, 32'hDEAD_BEEF, 32'h0000_0203, 32'h0000_0088, 32'h0,        32'h0,        32'h0000_0000, 32'd0,  32'h0000_0200, 32'h0000_0203, 32'h0000_1880, 32'h0000_0000};
    vecs[5] = '{6'b001111, 1'b0, 32'h0000_0080, 32'hCAFE_0073, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0,        32'h0,        32'hFFFF_FFFF, 32'd11, 32'h0000_0080, 32'h0,        32'hFFFF_FFF7, 32'hFFFF_FFFC};
    vecs[6] = '{6'b000111, 1'b0, 32'h0000_0300, 32'h0010_0073, 32'h0000_0077, 32'h0000_1808, 32'h0,        32'h0,        32'h0000_0400, 32'd3,  32'h0000_0300, 32'h0,        32'h0000_1880, 32'h0000_0400};
    vecs[7] = '{6'b000001, 1'b0, 32'h0000_0500, 32'h0,        32'hABCD_0002, 32'h0000_0000, 32'h0,        32'h0,        32'h0000_0600, 32'd6,  32'h0000_0500, 32'hABCD_0002, 32'h0000_1800, 32'h0000_0600};
    vecs[8] = '{6'b000000, 1'b1, 32'h0000_0700, 32'h0,        32'h0,        32'h0000_0000, 32'h0000_2000, 32'h0000_0004, 32'h0000_0000, 32'd4,  32'h0000_2000, 32'h0,        32'h0000_1880, 32'h0000_2000};

    // Reset state
    rst_i = 1'b1;
    clearEvents();
    pc_i = '0; instr_i = '0; badaddr_i = '0;
    mstatus_i = '0; mepc_i = '0; mcause_i = '0; mtvec_i = '0;
    stepClock();
    stepClock();
    checkOutput("reset.we_exc", 32'(we_exc_o), 32'd0);
    checkOutput("reset.busy", 32'(busy_o), 32'd0);
    checkOutput("reset.flush", 32'(flush_o), 32'd0);
    checkOutput("reset.redirect", 32'(redirect_o), 32'd0);
    checkOutput("reset.mcause", mcause_o, 32'd0);
    checkOutput("reset.mstatus", mstatus_o, 32'd0);
    checkOutput("reset.redirect_pc", redirect_pc_o, 32'd0);
    rst_i = 1'b0;
    stepClock();

    // Table-driven events: accept, CSR write, redirect, idle
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      stepClock();
      clearEvents();
      checkOutput($sformatf("v%0d.we_exc", i), 32'(we_exc_o), 32'd1);
      checkOutput($sformatf("v%0d.flush", i), 32'(flush_o), 32'd1);
      checkOutput($sformatf("v%0d.busy", i), 32'(busy_o), 32'd1);
      checkOutput($sformatf("v%0d.redirect_early", i), 32'(redirect_o), 32'd0);
      checkOutput($sformatf("v%0d.mcause", i), mcause_o, vecs[i].exp_mcause);
      checkOutput($sformatf("v%0d.mepc", i), mepc_o, vecs[i].exp_mepc);
      checkOutput($sformatf("v%0d.mtval", i), mtval_o, vecs[i].exp_mtval);
      checkOutput($sformatf("v%0d.mstatus", i), mstatus_o, vecs[i].exp_mstatus);
      stepClock();
      checkOutput($sformatf("v%0d.we_exc_off", i), 32'(we_exc_o), 32'd0);
      checkOutput($sformatf("v%0d.redirect", i), 32'(redirect_o), 32'd1);
      checkOutput($sformatf("v%0d.redirect_pc", i), redirect_pc_o, vecs[i].exp_redirect);
      checkOutput($sformatf("v%0d.busy_redir", i), 32'(busy_o), 32'd1);
      stepClock();
      checkOutput($sformatf("v%0d.idle_busy", i), 32'(busy_o), 32'd0);
      checkOutput($sformatf("v%0d.idle_redirect", i), 32'(redirect_o), 32'd0);
    end

    // Events held while busy are ignored; next accepted at N+3
    clearEvents();
    valid_i = 1'b1; ecall_i = 1'b1; pc_i = 32'h0000_0010;
    mstatus_i = 32'h0000_0008; mtvec_i = 32'h0000_0800;
    stepClock();
    checkOutput("busy.n1_we_exc", 32'(we_exc_o), 32'd1);
    checkOutput("busy.n1_mepc", mepc_o, 32'h0000_0010);
    checkOutput("busy.n1_mcause", mcause_o, 32'd11);
    stepClock();
    checkOutput("busy.n2_we_exc", 32'(we_exc_o), 32'd0);
    checkOutput("busy.n2_redirect", 32'(redirect_o), 32'd1);
    checkOutput("busy.n2_redirect_pc", redirect_pc_o, 32'h0000_0800);
    pc_i = 32'h0000_0014;
    stepClock();
    checkOutput("busy.n3_busy", 32'(busy_o), 32'd0);
    checkOutput("busy.n3_we_exc", 32'(we_exc_o), 32'd0);
    checkOutput("busy.n3_redirect", 32'(redirect_o), 32'd0);
    stepClock();
    clearEvents();
    checkOutput("busy.n4_we_exc", 32'(we_exc_o), 32'd1);
    checkOutput("busy.n4_mepc", mepc_o, 32'h0000_0014);
    checkOutput("busy.n4_mcause", mcause_o, 32'd11);
    checkOutput("busy.n4_mtval", mtval_o, 32'd0);
    stepClock();
    stepClock();

    // Reset during TRAP, then flags without valid_i
    valid_i = 1'b1; illegal_i = 1'b1; pc_i = 32'h0000_0900;
    instr_i = 32'h0000_00FF; mtvec_i = 32'h0000_0A00;
    stepClock();
    clearEvents();
    checkOutput("rst_trap.we_exc_before", 32'(we_exc_o), 32'd1);
    rst_i = 1'b1;
    stepClock();
    rst_i = 1'b0;
    checkOutput("rst_trap.we_exc", 32'(we_exc_o), 32'd0);
    checkOutput("rst_trap.redirect", 32'(redirect_o), 32'd0);
    checkOutput("rst_trap.busy", 32'(busy_o), 32'd0);
    checkOutput("rst_trap.mcause", mcause_o, 32'd0);
    illegal_i = 1'b1;
    stepClock();
    checkOutput("novalid.we_exc", 32'(we_exc_o), 32'd0);
    checkOutput("novalid.busy", 32'(busy_o), 32'd0);
    stepClock();
    checkOutput("novalid.redirect", 32'(redirect_o), 32'd0);
    clearEvents();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
